// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one memory port between instruction fetch and load/store
//   clk, rst : core clock, synchronous active-high reset
//   if_*     : fetch requester (req/addr in; ack/rdata/err out)
//   d_*      : load/store requester (req/we/addr/wdata/wstrb in; ack/rdata/err out)
//   mem_*    : unified memory port (req/we/addr/wdata/wstrb out; rvalid/rdata in)
//   MEM_ARB_RR_EN defined: round robin on simultaneous requests; undefined: d_req wins
module riscv_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  state_e            state_q, state_d;
  logic              gnt_d_q, gnt_d_d;
  logic              last_d_q, last_d_d;
  logic              err_q, err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [2:0]        d_bytes;
  logic              if_mis, d_mis, sel_d, sel_mis;
  logic [ADDR_W-1:0] sel_addr;
  assign d_bytes = 3'(d_wstrb[0]) + 3'(d_wstrb[1]) + 3'(d_wstrb[2]) + 3'(d_wstrb[3]);
  // a data access is misaligned only when its enabled bytes run past the end of the word
  assign d_mis = ({1'b0, d_addr[1:0]} + d_bytes) > 3'd4;
  assign if_mis = |if_addr[1:0];
`ifdef MEM_ARB_RR_EN
  // last_d_q = 1 means the data port won last time, so fetch gets a contested grant
  assign sel_d = d_req & (~if_req | ~last_d_q);
`else
  assign sel_d = d_req;
`endif
  assign sel_mis = sel_d ? d_mis : if_mis;
  assign sel_addr = sel_d ? d_addr : if_addr;
  always_comb begin
    state_d = state_q;
    gnt_d_d = gnt_d_q;
    last_d_d = last_d_q;
    err_d = err_q;
    mem_req_d = mem_req_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: if (if_req | d_req) begin
        gnt_d_d = sel_d;
        last_d_d = sel_d;
        err_d = sel_mis;
        mem_req_d = ~sel_mis;
        mem_we_d = sel_d & d_we;
        mem_addr_d = {sel_addr[ADDR_W-1:2], 2'b00};
        mem_wdata_d = sel_d ? d_wdata : '0;
        mem_wstrb_d = (sel_d & d_we) ? d_wstrb : 4'b0;
        state_d = sel_mis ? RESP : BUSY;
      end
      BUSY: if (mem_rvalid) begin
        mem_req_d = 1'b0;
        if_rdata_d = gnt_d_q ? if_rdata_q : mem_rdata;
        d_rdata_d = (gnt_d_q & ~mem_we_q) ? mem_rdata : d_rdata_q;
        state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_d_q <= 1'b0;
      last_d_q <= 1'b0;
      err_q <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= 4'b0;
      if_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_d_q <= gnt_d_d;
      last_d_q <= last_d_d;
      err_q <= err_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  assign if_ack = (state_q == RESP) & ~gnt_d_q;
  assign d_ack = (state_q == RESP) & gnt_d_q;
  assign if_err = if_ack & err_q;
  assign d_err = d_ack & err_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata = d_rdata_q;
  assign mem_req = mem_req_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
endmodule
